// File: rtl/eth_xcvr_reset_ctrl.sv
// Transceiver reset sequencer: shared QPLL bring-up plus per-channel TX/RX datapath
// reset handling with RX request stretching, done-timeout retry and hold-off.
module eth_xcvr_reset_ctrl #(
  parameter int CH_COUNT         = 4,
  parameter int PLL_RESET_CYCLES = 16,
  parameter int LOCK_TIMEOUT     = 65536,
  parameter int RX_RESET_CYCLES  = 8,
  parameter int DONE_TIMEOUT     = 4096,
  parameter int HOLDOFF_CYCLES   = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                qpll_lock_in,
  output logic                qpll_reset_out,
  output logic                pll_locked,
  output logic [7:0]          pll_retry_count,
  input  logic [CH_COUNT-1:0] tx_reset_done_in,
  input  logic [CH_COUNT-1:0] rx_reset_done_in,
  input  logic [CH_COUNT-1:0] rx_reset_req_in,
  output logic [CH_COUNT-1:0] tx_datapath_reset,
  output logic [CH_COUNT-1:0] rx_datapath_reset,
  output logic [CH_COUNT-1:0] ch_up,
  output logic [CH_COUNT-1:0] ch_rx_timeout
);

  localparam int G_MAX  = (PLL_RESET_CYCLES > LOCK_TIMEOUT) ? PLL_RESET_CYCLES : LOCK_TIMEOUT;
  localparam int G_W    = $clog2(G_MAX + 1);
  localparam int C_MAX0 = (RX_RESET_CYCLES > DONE_TIMEOUT) ? RX_RESET_CYCLES : DONE_TIMEOUT;
  localparam int C_MAX  = (C_MAX0 > HOLDOFF_CYCLES) ? C_MAX0 : HOLDOFF_CYCLES;
  localparam int C_W    = $clog2(C_MAX + 1);
  localparam int SW     = 1 + 3 * CH_COUNT;

  localparam logic [G_W-1:0] PLL_RST_LOAD = G_W'(PLL_RESET_CYCLES - 1);
  localparam logic [G_W-1:0] LOCK_LOAD    = G_W'(LOCK_TIMEOUT - 1);
  localparam logic [G_W-1:0] G_ONE        = G_W'(1);
  localparam logic [C_W-1:0] RX_LOAD      = C_W'(RX_RESET_CYCLES - 1);
  localparam logic [C_W-1:0] DONE_LOAD    = C_W'(DONE_TIMEOUT - 1);
  localparam logic [C_W-1:0] HOLD_LOAD    = C_W'(HOLDOFF_CYCLES - 1);
  localparam logic [C_W-1:0] C_ONE        = C_W'(1);

  typedef enum logic [1:0] {PLL_RST, PLL_WAIT, RUN} g_state_t;
  typedef enum logic [2:0] {CH_OFF, CH_IDLE, CH_PULSE, CH_WAIT, CH_HOLD} ch_state_t;

  logic [SW-1:0]       sync1, sync2;
  logic                lock_s;
  logic [CH_COUNT-1:0] tx_done_s, rx_done_s, req_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      // NOTE: non-blocking assignments so sync2 takes the old sync1, giving two real flops.
      sync1 <= {rx_reset_req_in, rx_reset_done_in, tx_reset_done_in, qpll_lock_in};
      sync2 <= sync1;
    end
  end

  assign {req_s, rx_done_s, tx_done_s, lock_s} = sync2;

  g_state_t            g_state, g_next;
  logic [G_W-1:0]      g_cnt, g_cnt_next;
  logic                retry_inc;
  ch_state_t           ch_state [CH_COUNT];
  ch_state_t           ch_next  [CH_COUNT];
  logic [C_W-1:0]      ch_cnt      [CH_COUNT];
  logic [C_W-1:0]      ch_cnt_next [CH_COUNT];
  logic [CH_COUNT-1:0] seen_low, seen_low_next, timeout_d;
  logic                qpll_reset_d, locked_d;
  logic [CH_COUNT-1:0] rx_rst_d, up_d;

  // Next-state logic: global sequencer first, then channels keyed off its next state.
  always_comb begin
    // NOTE: every comb output gets a default before the case so no latch is inferred.
    g_next     = g_state;
    g_cnt_next = g_cnt;
    retry_inc  = 1'b0;
    case (g_state)
      PLL_RST:
        if (g_cnt == '0) begin
          g_next     = PLL_WAIT;
          g_cnt_next = LOCK_LOAD;
        end else g_cnt_next = g_cnt - G_ONE;
      PLL_WAIT:
        if (lock_s) g_next = RUN;
        else if (g_cnt == '0) begin
          g_next     = PLL_RST;
          g_cnt_next = PLL_RST_LOAD;
          retry_inc  = 1'b1;
        end else g_cnt_next = g_cnt - G_ONE;
      RUN:
        if (!lock_s) begin
          g_next     = PLL_RST;
          g_cnt_next = PLL_RST_LOAD;
          retry_inc  = 1'b1;
        end
      default: begin
        g_next     = PLL_RST;
        g_cnt_next = PLL_RST_LOAD;
      end
    endcase

    for (int i = 0; i < CH_COUNT; i++) begin
      ch_next[i]       = ch_state[i];
      ch_cnt_next[i]   = ch_cnt[i];
      seen_low_next[i] = seen_low[i];
      timeout_d[i]     = 1'b0;
      // Leaving RUN overrides whatever the channel would have done this cycle.
      if (g_next != RUN) ch_next[i] = CH_OFF;
      else case (ch_state[i])
        CH_OFF: begin
          ch_next[i]       = CH_WAIT;
          ch_cnt_next[i]   = DONE_LOAD;
          seen_low_next[i] = 1'b1;
        end
        CH_IDLE:
          if (req_s[i]) begin
            ch_next[i]       = CH_PULSE;
            ch_cnt_next[i]   = RX_LOAD;
            seen_low_next[i] = 1'b0;
          end
        CH_PULSE:
          if (ch_cnt[i] == '0) begin
            ch_next[i]     = CH_WAIT;
            ch_cnt_next[i] = DONE_LOAD;
          end else ch_cnt_next[i] = ch_cnt[i] - C_ONE;
        CH_WAIT:
          if (rx_done_s[i] && seen_low[i]) begin
            ch_next[i]     = CH_HOLD;
            ch_cnt_next[i] = HOLD_LOAD;
          end else if (ch_cnt[i] == '0) begin
            ch_next[i]       = CH_PULSE;
            ch_cnt_next[i]   = RX_LOAD;
            seen_low_next[i] = 1'b0;
            timeout_d[i]     = 1'b1;
          end else begin
            ch_cnt_next[i] = ch_cnt[i] - C_ONE;
            if (!rx_done_s[i]) seen_low_next[i] = 1'b1;
          end
        CH_HOLD:
          if (ch_cnt[i] == '0) ch_next[i] = CH_IDLE;
          else ch_cnt_next[i] = ch_cnt[i] - C_ONE;
        default: ch_next[i] = CH_OFF;
      endcase
    end
  end

  // Outputs decoded from the next state so the registered outputs line up with the state.
  always_comb begin
    qpll_reset_d = (g_next == PLL_RST);
    locked_d     = (g_next == RUN);
    for (int i = 0; i < CH_COUNT; i++) begin
      rx_rst_d[i] = (ch_next[i] == CH_OFF) || (ch_next[i] == CH_PULSE);
      up_d[i]     = ((ch_next[i] == CH_IDLE) || (ch_next[i] == CH_HOLD)) &&
                    tx_done_s[i] && rx_done_s[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_state           <= PLL_RST;
      g_cnt             <= PLL_RST_LOAD;
      seen_low          <= '0;
      qpll_reset_out    <= 1'b1;
      pll_locked        <= 1'b0;
      pll_retry_count   <= 8'd0;
      tx_datapath_reset <= '1;
      rx_datapath_reset <= '1;
      ch_up             <= '0;
      ch_rx_timeout     <= '0;
      for (int i = 0; i < CH_COUNT; i++) begin
        ch_state[i] <= CH_OFF;
        ch_cnt[i]   <= '0;
      end
    end else begin
      g_state           <= g_next;
      g_cnt             <= g_cnt_next;
      seen_low          <= seen_low_next;
      qpll_reset_out    <= qpll_reset_d;
      pll_locked        <= locked_d;
      if (retry_inc && (pll_retry_count != 8'hFF))
        pll_retry_count <= pll_retry_count + 8'd1;
      tx_datapath_reset <= {CH_COUNT{!locked_d}};
      rx_datapath_reset <= rx_rst_d;
      ch_up             <= up_d;
      ch_rx_timeout     <= timeout_d;
      for (int i = 0; i < CH_COUNT; i++) begin
        ch_state[i] <= ch_next[i];
        ch_cnt[i]   <= ch_cnt_next[i];
      end
    end
  end

endmodule

// File: tb/tb_eth_xcvr_reset_ctrl.sv
// Directed bench for eth_xcvr_reset_ctrl: bring-up, RX requests, done timeout,
// hold-off, lock loss, async reset and lock-timeout retry with saturation.
module tb_eth_xcvr_reset_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       qpll_lock_in = 1'b1;
  logic       qpll_reset_out, pll_locked;
  logic [7:0] pll_retry_count;
  logic [3:0] tx_reset_done_in = 4'hF;
  logic [3:0] rx_reset_done_in = 4'hF;
  logic [3:0] rx_reset_req_in  = 4'h0;
  logic [3:0] tx_datapath_reset, rx_datapath_reset, ch_up, ch_rx_timeout;

  int checks   = 0;
  int failures = 0;

  eth_xcvr_reset_ctrl #(.CH_COUNT(4), .PLL_RESET_CYCLES(16), .LOCK_TIMEOUT(100),
                        .RX_RESET_CYCLES(8), .DONE_TIMEOUT(4096), .HOLDOFF_CYCLES(1024)) dut (
    .clk(clk), .rst(rst), .qpll_lock_in(qpll_lock_in), .qpll_reset_out(qpll_reset_out),
    .pll_locked(pll_locked), .pll_retry_count(pll_retry_count),
    .tx_reset_done_in(tx_reset_done_in), .rx_reset_done_in(rx_reset_done_in),
    .rx_reset_req_in(rx_reset_req_in), .tx_datapath_reset(tx_datapath_reset),
    .rx_datapath_reset(rx_datapath_reset), .ch_up(ch_up), .ch_rx_timeout(ch_rx_timeout));

  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_values(input string tag);
    checks++;
    if ({qpll_reset_out, pll_locked, pll_retry_count, tx_datapath_reset, rx_datapath_reset,
         ch_up, ch_rx_timeout} !== {1'b1, 1'b0, 8'd0, 4'hF, 4'hF, 4'h0, 4'h0}) begin
      failures++;
      $display("FAIL %s: got qrst=%b lock=%b retry=%0d txr=%h rxr=%h up=%h to=%h, expected 1 0 0 f f 0 0",
               tag, qpll_reset_out, pll_locked, pll_retry_count, tx_datapath_reset,
               rx_datapath_reset, ch_up, ch_rx_timeout);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_reset_values("reset_state");
  endtask

  task automatic test_bringup();
    int n = 0;
    rst = 1'b0;
    while (qpll_reset_out && n < 100) begin n++; @(negedge clk); end
    checks++;
    if (n !== 16) begin failures++; $display("FAIL qpll_reset_width: got %0d expected 16", n); end
    n = 0;
    while (!pll_locked && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (n !== 1) begin failures++; $display("FAIL lock_latency: got %0d expected 1", n); end
    checks++;
    if ({tx_datapath_reset, rx_datapath_reset} !== 8'h00) begin
      failures++; $display("FAIL run_resets: got txr=%h rxr=%h expected 0 0", tx_datapath_reset, rx_datapath_reset);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (ch_up !== 4'hF) begin failures++; $display("FAIL bringup_ch_up: got %h expected f", ch_up); end
  endtask

  task automatic test_rx_req();
    int n = 0, w = 0, bad_up = 0, bad_other = 0;
    repeat (1100) @(negedge clk);
    rx_reset_req_in[2] = 1'b1;
    while (!rx_datapath_reset[2] && n < 10) begin
      @(negedge clk); n++;
      if (n == 1) rx_reset_req_in[2] = 1'b0;
    end
    checks++;
    if (n !== 3) begin failures++; $display("FAIL req_latency: got %0d expected 3", n); end
    rx_reset_done_in[2] = 1'b0;
    while (rx_datapath_reset[2] && w < 20) begin
      if (ch_up[2]) bad_up++;
      if ((rx_datapath_reset & 4'b1011) != 4'h0 || (ch_up & 4'b1011) != 4'b1011) bad_other++;
      w++; @(negedge clk);
    end
    checks++;
    if (w !== 8) begin failures++; $display("FAIL ch2_pulse_width: got %0d expected 8", w); end
    checks++;
    if (bad_other !== 0) begin failures++; $display("FAIL other_channels: got %0d disturbed cycles expected 0", bad_other); end
    rx_reset_done_in[2] = 1'b1;
    n = 0;
    while (!ch_up[2] && n < 20) begin
      if (rx_datapath_reset[2]) bad_up++;
      @(negedge clk); n++;
    end
    checks++;
    if (n !== 3) begin failures++; $display("FAIL ch2_wait_to_hold: got %0d expected 3", n); end
    checks++;
    if (bad_up !== 0) begin failures++; $display("FAIL ch2_up_during_seq: got %0d bad cycles expected 0", bad_up); end
  endtask

  task automatic test_done_timeout();
    int n = 0, w = 0, tcnt = 0;
    rx_reset_req_in[0] = 1'b1;
    @(negedge clk);
    rx_reset_req_in[0] = 1'b0;
    while (!rx_datapath_reset[0] && n < 10) begin @(negedge clk); n++; end
    while (rx_datapath_reset[0] && w < 20) begin w++; @(negedge clk); end
    checks++;
    if (w !== 8) begin failures++; $display("FAIL ch0_pulse_width: got %0d expected 8", w); end
    n = 0;
    while (!ch_rx_timeout[0] && n < 5000) begin @(negedge clk); n++; end
    checks++;
    if (n !== 4096) begin failures++; $display("FAIL ch0_timeout_delay: got %0d expected 4096", n); end
    checks++;
    if ({ch_rx_timeout, rx_datapath_reset[0]} !== 5'b0001_1) begin
      failures++; $display("FAIL ch0_timeout_repulse: got to=%h rxr0=%b expected 1 1", ch_rx_timeout, rx_datapath_reset[0]);
    end
    w = 0;
    while (rx_datapath_reset[0] && w < 20) begin
      if (ch_rx_timeout[0]) tcnt++;
      w++; @(negedge clk);
    end
    checks++;
    if ({w, tcnt} !== {32'd8, 32'd1}) begin
      failures++; $display("FAIL ch0_repulse: got width=%0d timeout_cycles=%0d expected 8 1", w, tcnt);
    end
    rx_reset_done_in[0] = 1'b0;
    repeat (6) @(negedge clk);
    rx_reset_done_in[0] = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (ch_up[0] !== 1'b1) begin failures++; $display("FAIL ch0_recovered: got %b expected 1", ch_up[0]); end
  endtask

  task automatic test_holdoff();
    int rise_t [3];
    int nr = 0, hi = 0, tout = 0, w = 0;
    logic prev = 1'b0;
    rx_reset_req_in[1] = 1'b1;
    for (int c = 0; c < 3300 && nr < 3; c++) begin
      @(negedge clk);
      if (ch_rx_timeout != 4'h0) tout++;
      if (rx_datapath_reset[1] && !prev) begin
        rise_t[nr] = c; nr++; rx_reset_done_in[1] = 1'b0;
      end
      if (!rx_datapath_reset[1] && prev) rx_reset_done_in[1] = 1'b1;
      if (rx_datapath_reset[1] && nr < 3) hi++;
      prev = rx_datapath_reset[1];
    end
    rx_reset_req_in[1] = 1'b0;
    checks++;
    if (nr !== 3) begin
      failures++; $display("FAIL holdoff_pulses: got %0d pulses expected 3", nr);
    end else begin
      // 8 pulse + 3 wait (sync latency on rx_done) + 1024 hold-off + 1 idle
      checks++;
      if ({rise_t[1] - rise_t[0], rise_t[2] - rise_t[1]} !== {32'd1036, 32'd1036}) begin
        failures++; $display("FAIL holdoff_spacing: got %0d %0d expected 1036 1036",
                             rise_t[1] - rise_t[0], rise_t[2] - rise_t[1]);
      end
    end
    checks++;
    if ({hi, tout} !== {32'd16, 32'd0}) begin
      failures++; $display("FAIL holdoff_high_cycles: got high=%0d timeouts=%0d expected 16 0", hi, tout);
    end
    while (rx_datapath_reset[1] && w < 20) begin w++; @(negedge clk); end
    rx_reset_done_in[1] = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_lock_loss();
    int n = 0;
    rx_reset_req_in[3] = 1'b1;
    @(negedge clk);
    rx_reset_req_in[3] = 1'b0;
    while (!rx_datapath_reset[3] && n < 10) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    qpll_lock_in = 1'b0;
    n = 0;
    while (pll_locked && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (n !== 3) begin failures++; $display("FAIL lock_loss_latency: got %0d expected 3", n); end
    checks++;
    if ({qpll_reset_out, tx_datapath_reset, rx_datapath_reset, ch_up, pll_retry_count} !==
        {1'b1, 4'hF, 4'hF, 4'h0, 8'd1}) begin
      failures++; $display("FAIL lock_loss_state: got qrst=%b txr=%h rxr=%h up=%h retry=%0d expected 1 f f 0 1",
                           qpll_reset_out, tx_datapath_reset, rx_datapath_reset, ch_up, pll_retry_count);
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    qpll_lock_in = 1'b1;
    while (!pll_locked && n < 200) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    checks++;
    if ({pll_locked, ch_up} !== 5'b1_1111) begin
      failures++; $display("FAIL relock: got lock=%b up=%h expected 1 f", pll_locked, ch_up);
    end
    #2 rst = 1'b1;
    #1 check_reset_values("async_reset");
    repeat (3) @(negedge clk);
  endtask

  task automatic test_lock_timeout();
    int r [3];
    int rc [3];
    int nr = 0, hi = 0;
    logic prev = 1'b1;
    qpll_lock_in = 1'b0;
    rst = 1'b0;
    for (int c = 1; c <= 400 && nr < 3; c++) begin
      @(negedge clk);
      if (qpll_reset_out && !prev) begin r[nr] = c; rc[nr] = pll_retry_count; nr++; end
      if (nr == 1 && qpll_reset_out) hi++;
      prev = qpll_reset_out;
    end
    checks++;
    if (nr !== 3) begin
      failures++; $display("FAIL timeout_loops: got %0d re-pulses expected 3", nr);
    end else begin
      checks++;
      if ({r[0], r[1] - r[0], r[2] - r[1]} !== {32'd116, 32'd116, 32'd116}) begin
        failures++; $display("FAIL timeout_period: got %0d %0d %0d expected 116 116 116",
                             r[0], r[1] - r[0], r[2] - r[1]);
      end
      checks++;
      if ({rc[0], rc[2]} !== {32'd1, 32'd3}) begin
        failures++; $display("FAIL retry_count_loops: got %0d %0d expected 1 3", rc[0], rc[2]);
      end
    end
    checks++;
    if (hi !== 16) begin failures++; $display("FAIL timeout_reset_width: got %0d expected 16", hi); end
    repeat (116 * 254) @(negedge clk);
    checks++;
    if (pll_retry_count !== 8'd255) begin failures++; $display("FAIL retry_reach_255: got %0d expected 255", pll_retry_count); end
    repeat (116 * 2) @(negedge clk);
    checks++;
    if (pll_retry_count !== 8'd255) begin failures++; $display("FAIL retry_saturate: got %0d expected 255", pll_retry_count); end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_rx_req();
    test_done_timeout();
    test_holdoff();
    test_lock_loss();
    test_async_reset();
    test_lock_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
